dht11_reader: RTL
=================

Name: dht11_reader

Overview:
- Single-wire DHT11 transaction engine. On a `start` request it runs one full read of the sensor and returns humidity and temperature bytes with a checksum verdict.
- Sits downstream of the command decode of the two UART bytes received from the PC, and upstream of `uart_tx`, which serialises the selected result back to the PC.
- The top level owns the open-drain pad: it drives the pin low when `dht_drive_low`=1, otherwise releases it to the pull-up.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used to derive the 1 µs tick.
- START_LOW_US, 19000, host start pulse length (spec minimum is 18 ms).
- TIMEOUT_US, 120, maximum time allowed in any sensor-driven line level before aborting.
- BIT1_THRESH_US, 48, high-time threshold: a bit whose high time is greater than this is 1, otherwise 0.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- dht_in  in  1  raw pad level (asynchronous to `clock`)
- dht_drive_low  out  1  1 = pull data line low
- busy  out  1  high from start acceptance until `done`
- done  out  1  one-cycle pulse at the end of every transaction, good or bad
- error  out  1  valid with `done`; held until the next accepted start
- error_code  out  2  00 ok, 01 no sensor response, 10 bit timeout, 11 checksum mismatch
- humidity_int  out  8  humidity integer byte from the last good read
- humidity_dec  out  8  humidity decimal byte from the last good read
- temperature_int  out  8  temperature integer byte from the last good read
- temperature_dec  out  8  temperature decimal byte from the last good read

Behaviour:
- Reset (asynchronous):
  - all outputs 0, `dht_drive_low`=0 (line released), state IDLE.
  - Reset asserted mid-transaction releases the line immediately; no `done` is generated.
- Input conditioning:
  - `dht_in` passes through a 2-FF synchroniser.
  - Rise and fall are detected on the synchronised level. Edge-to-state latency is 3 cycles; this is tolerated.
- Timebase:
  - A free-running prescaler emits a 1-cycle `tick_us` every CLK_HZ/1000000 clocks.
  - A 15-bit µs counter clears on every state change and increments on each `tick_us`.
- FSM:
  - IDLE: `start`=1 → START_LOW. Clear `error`, `error_code`, the 40-bit shift register and the bit index. `busy`=1.
  - START_LOW: `dht_drive_low`=1. Stay until the counter reaches START_LOW_US → WAIT_ACK.
  - WAIT_ACK: line released. Falling edge → ACK_LOW. Counter > TIMEOUT_US → FAIL with code 01.
  - ACK_LOW: rising edge → ACK_HIGH. Timeout → FAIL 01.
  - ACK_HIGH: falling edge → BIT_LOW. Timeout → FAIL 01.
  - BIT_LOW: rising edge → BIT_HIGH. Timeout → FAIL 10.
  - BIT_HIGH: on a falling edge:
    - shift in (counter > BIT1_THRESH_US), MSB first, and increment the bit index;
    - if the index was 39 → CHECK, else → BIT_LOW.
    - Timeout → FAIL 10.
  - CHECK (1 cycle):
    - compare (b0+b1+b2+b3) mod 256 with b4, using an 8-bit wrapping sum;
    - equal → update the four data outputs, → FINISH;
    - not equal → FAIL 11.
  - FAIL (1 cycle): `error`=1, latch the code, data outputs unchanged → FINISH.
  - FINISH (1 cycle): `done`=1, `busy`=0 → IDLE.
- `start` while busy: ignored, with no queueing.
- Simultaneous edge and timeout in the same cycle: the edge wins.
- The final sensor release after bit 39 is not waited for.
- Enforcing the 1 s minimum spacing between reads is the caller's responsibility.
- The data outputs change only in CHECK-pass, so they are stable for `uart_tx` at all other times.

Decomposition:
- Package `dht11_pkg` holds:
  - the state enum (IDLE, START_LOW, WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, CHECK, FAIL, FINISH);
  - the error-code constants (ERR_NONE, ERR_NO_RESP, ERR_BIT_TMO, ERR_CHECKSUM);
  - the frame length constant 40.
- One sub-module: `dht11_us_tick`, the prescaler producing `tick_us`. Parameter CLK_HZ; ports `clock`, `reset_n`, `tick_us`.

Test Plan:
- Good frame: sensor model answers with ACK 80 µs low / 80 µs high, then bytes 0x37,0x00,0x19,0x00,0x50 → `done` pulse, `error`=0, `humidity_int`=55, `temperature_int`=25, `dht_drive_low` high for 19000±1 µs.
- Checksum fail: first send a good frame, then bytes 0x37,0x00,0x19,0x00,0x51 → `error`=1, `error_code`=11, outputs still hold the earlier good values.
- No sensor (line held high) → `done` about 120 µs after release, `error_code`=01, `busy` falls in the same cycle that `done` rises.
- Sensor stops after bit 12, line stuck low → `error_code`=10, `done` after a BIT_LOW timeout.
- Boundaries: high times of 47 µs and 49 µs decode as 0 and 1. Checksum wrap: 0xFF,0xFF,0x01,0x03 with checksum 0x02 passes.
- Reset asserted during BIT_HIGH → `dht_drive_low`=0 and all outputs 0 without waiting for a clock edge. A second `start` while busy is ignored; exactly one `done` follows.

Source files
------------

// File: rtl/dht11_pkg.sv
// dht11_pkg: shared FSM states, error codes and frame constants for the DHT11 reader
package dht11_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START_LOW,
        WAIT_ACK,
        ACK_LOW,
        ACK_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK,
        FAIL,
        FINISH
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_NO_RESP  = 2'b01;
    localparam logic [1:0] ERR_BIT_TMO  = 2'b10;
    localparam logic [1:0] ERR_CHECKSUM = 2'b11;

    localparam int FRAME_BITS = 40;

    // Frame is b0..b4 from MSB down; b4 must equal the 8-bit wrapping sum of b0..b3
    function automatic logic csum_ok(input logic [39:0] f);
        logic [7:0] s;
        s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        return s == f[7:0];
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: free-running prescaler emitting a one-cycle pulse every microsecond
module dht11_us_tick #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick_us
);

    localparam int DIV = CLK_HZ / 1000000;
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] pre_q, pre_d;

    assign tick_us = pre_q == LAST;

    // Wrap the divider on the tick cycle
    always_comb pre_d = tick_us ? '0 : pre_q + 1'b1;

    // Divider register
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) pre_q <= '0;
        else pre_q <= pre_d;

endmodule

// File: rtl/dht11_reader.sv
// dht11_reader: single-wire DHT11 transaction engine returning humidity/temperature with a checksum verdict
module dht11_reader
    import dht11_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int START_LOW_US   = 19000,
    parameter int TIMEOUT_US     = 120,
    parameter int BIT1_THRESH_US = 48
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       dht_in,
    output logic       dht_drive_low,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] error_code,
    output logic [7:0] humidity_int,
    output logic [7:0] humidity_dec,
    output logic [7:0] temperature_int,
    output logic [7:0] temperature_dec
);

    localparam logic [14:0] START_LIM = 15'(START_LOW_US);
    localparam logic [14:0] TMO_LIM   = 15'(TIMEOUT_US);
    localparam logic [14:0] THR_LIM   = 15'(BIT1_THRESH_US);
    localparam logic [5:0]  LAST_IDX  = 6'(FRAME_BITS - 1);

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic [14:0] cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [39:0] shift_q, shift_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  pend_q, pend_d, code_q, code_d;
    logic        err_q, err_d;
    logic        tick_us, rise, fall, tmo;

    dht11_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .tick_us(tick_us)
    );

    // sync_q[1] is the synchronised level, sync_q[2] its previous value for edge detection
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];
    assign tmo  = cnt_q > TMO_LIM;

    assign dht_drive_low = state_q == START_LOW;
    assign busy          = state_q != IDLE && state_q != FINISH;
    assign done          = state_q == FINISH;
    assign error         = err_q;
    assign error_code    = code_q;
    assign {humidity_int, humidity_dec, temperature_int, temperature_dec} = data_q;

    // Synchroniser shift and microsecond counter that restarts on every state change
    always_comb begin
        sync_d = {sync_q[1:0], dht_in};
        cnt_d  = state_d != state_q ? '0 : cnt_q + {14'd0, tick_us};
    end

    // Next-state logic; an edge always takes priority over a timeout seen in the same cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        pend_d  = pend_q;
        code_d  = code_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = START_LOW;
                err_d   = 1'b0;
                code_d  = ERR_NONE;
                shift_d = '0;
                idx_d   = '0;
            end
            START_LOW: if (cnt_q >= START_LIM) state_d = WAIT_ACK;
            WAIT_ACK:  state_d = fall ? ACK_LOW  : tmo ? FAIL : WAIT_ACK;
            ACK_LOW:   state_d = rise ? ACK_HIGH : tmo ? FAIL : ACK_LOW;
            ACK_HIGH:  state_d = fall ? BIT_LOW  : tmo ? FAIL : ACK_HIGH;
            BIT_LOW:   state_d = rise ? BIT_HIGH : tmo ? FAIL : BIT_LOW;
            BIT_HIGH: if (fall) begin
                shift_d = {shift_q[38:0], cnt_q > THR_LIM};
                idx_d   = idx_q + 6'd1;
                state_d = idx_q == LAST_IDX ? CHECK : BIT_LOW;
            end else if (tmo) state_d = FAIL;
            CHECK: if (csum_ok(shift_q)) begin
                data_d  = shift_q[39:8];
                state_d = FINISH;
            end else begin
                pend_d  = ERR_CHECKSUM;
                state_d = FAIL;
            end
            FAIL: begin
                err_d   = 1'b1;
                code_d  = pend_q;
                state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == FAIL && state_q != CHECK && state_q != FAIL)
            pend_d = state_q inside {WAIT_ACK, ACK_LOW, ACK_HIGH} ? ERR_NO_RESP : ERR_BIT_TMO;
    end

    // State and datapath registers; the line idles high so the synchroniser resets to 1
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            sync_q  <= 3'b111;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            pend_q  <= ERR_NONE;
            code_q  <= ERR_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end

endmodule
